// File: rtl/trans_ledger_validator.sv
// Ledger-backed transfer validator: multi-lane account lookup, tentative
// allocation, funds/capacity/overflow checks, then two-step ledger commit.
module trans_ledger_validator #(
  parameter int ID_W     = 48,
  parameter int BAL_W    = 24,
  parameter int AMT_W    = 22,
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 8192,
  parameter int LANES    = 4,
  parameter int INIT_BAL = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [ID_W-1:0]          sender_i,
  input  logic [ID_W-1:0]          receiver_i,
  input  logic [AMT_W-1:0]         amount_i,
  input  logic                     block_start_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     reject_o,
  output logic [1:0]               reason_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LB = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ALLOC, S_CHECK, S_WR_S, S_WR_R
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_snd, r_rcv;
  logic [AMT_W-1:0]   r_amt;
  logic               r_self;
  logic [CW-1:0]      r_n, r_nb, r_scan;
  logic               r_rd_vld;
  logic [CW-1:0]      r_rd_base;
  logic [ID_W-1:0]    r_rd_id  [LANES];
  logic [BAL_W-1:0]   r_rd_bal [LANES];
  logic               r_fs, r_fr;
  logic [CW-1:0]      r_fs_idx, r_fr_idx;
  logic [BAL_W-1:0]   r_fs_bal, r_fr_bal;
  logic [CW-1:0]      r_s_idx, r_r_idx;
  logic [BAL_W-1:0]   r_s_bal, r_r_bal;
  logic [1:0]         r_new;
  logic [ID_W-1:0]    r_mem_id  [DEPTH];
  logic [BAL_W-1:0]   r_mem_bal [DEPTH];

  logic [CW-1:0]      w_n, w_nb, w_rd_base;
  logic               w_rd_en, w_we;
  logic [AW-1:0]      w_wr_addr;
  logic [ID_W-1:0]    w_wr_id;
  logic [BAL_W-1:0]   w_wr_bal, w_amt;
  logic [BAL_W:0]     w_sum;
  logic               w_full, w_funds, w_ovf;
  logic [CW-1:0]      w_lidx [LANES];
  logic               w_hs, w_hr;
  logic [CW-1:0]      w_hs_idx, w_hr_idx;
  logic [BAL_W-1:0]   w_hs_bal, w_hr_bal;

  assign w_amt     = BAL_W'(r_amt);
  assign w_n       = block_start_i ? '0 : count_o;
  assign w_nb      = CW'(({1'b0, w_n} + (CW+1)'(LANES - 1)) >> LB);
  assign w_rd_en   = (r_state == S_SCAN) && (r_scan < r_nb);
  assign w_rd_base = r_scan << LB;
  assign w_sum     = {1'b0, r_r_bal} + {1'b0, w_amt};
  assign w_full    = CW'(r_new) > (CW'(DEPTH) - r_n);
  assign w_funds   = r_s_bal < w_amt;
  assign w_ovf     = !r_self && w_sum[BAL_W];

  assign w_we      = !rst && (r_state == S_WR_S || r_state == S_WR_R);
  assign w_wr_addr = AW'((r_state == S_WR_S) ? r_s_idx : r_r_idx);
  assign w_wr_id   = (r_state == S_WR_S) ? r_snd : r_rcv;
  assign w_wr_bal  = (r_state == S_WR_S) ? r_s_bal - w_amt :
                     r_self ? r_s_bal : r_r_bal + w_amt;

  // Lanes scanned high to low so the lowest matching index wins the batch.
  always_comb begin
    w_hs = 1'b0; w_hs_idx = '0; w_hs_bal = '0;
    w_hr = 1'b0; w_hr_idx = '0; w_hr_bal = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      w_lidx[l] = r_rd_base + CW'(l);
      if (r_rd_vld && w_lidx[l] < r_n && r_rd_id[l] == r_snd) begin
        w_hs = 1'b1; w_hs_idx = w_lidx[l]; w_hs_bal = r_rd_bal[l];
      end
      if (r_rd_vld && w_lidx[l] < r_n && r_rd_id[l] == r_rcv) begin
        w_hr = 1'b1; w_hr_idx = w_lidx[l]; w_hr_bal = r_rd_bal[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem_id[w_wr_addr]  <= w_wr_id;
      r_mem_bal[w_wr_addr] <= w_wr_bal;
    end
    if (w_rd_en) begin
      for (int l = 0; l < LANES; l++) begin
        r_rd_id[l]  <= r_mem_id[AW'(w_rd_base) + AW'(l)];
        r_rd_bal[l] <= r_mem_bal[AW'(w_rd_base) + AW'(l)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      reject_o <= 1'b0;
      reason_o <= 2'd0;
      data_o   <= '0;
      count_o  <= '0;
      r_rd_vld <= 1'b0;
      r_scan   <= '0;
    end else begin
      valid_o  <= 1'b0;
      reject_o <= 1'b0;
      r_rd_vld <= w_rd_en;
      if (w_rd_en) r_rd_base <= w_rd_base;
      unique case (r_state)
        S_IDLE: begin
          if (valid_i && ready_o) begin
            ready_o <= 1'b0;
            r_snd   <= sender_i;
            r_rcv   <= receiver_i;
            r_amt   <= amount_i;
            r_self  <= sender_i == receiver_i;
            data_o  <= data_i;
            r_n     <= w_n;
            r_nb    <= w_nb;
            r_scan  <= '0;
            r_fs    <= 1'b0;
            r_fr    <= 1'b0;
            r_state <= S_SCAN;
          end else begin
            ready_o <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_hs && !r_fs) begin
            r_fs <= 1'b1; r_fs_idx <= w_hs_idx; r_fs_bal <= w_hs_bal;
          end
          if (w_hr && !r_fr) begin
            r_fr <= 1'b1; r_fr_idx <= w_hr_idx; r_fr_bal <= w_hr_bal;
          end
          r_scan <= r_scan + 1'b1;
          if (r_scan == r_nb) r_state <= S_ALLOC;
        end
        S_ALLOC: begin
          r_s_idx <= r_fs ? r_fs_idx : r_n;
          r_s_bal <= r_fs ? r_fs_bal : BAL_W'(INIT_BAL);
          if (r_self) begin
            r_r_idx <= r_fs ? r_fs_idx : r_n;
            r_r_bal <= r_fs ? r_fs_bal : BAL_W'(INIT_BAL);
            r_new   <= {1'b0, ~r_fs};
          end else begin
            r_r_idx <= r_fr ? r_fr_idx : (r_fs ? r_n : r_n + 1'b1);
            r_r_bal <= r_fr ? r_fr_bal : BAL_W'(INIT_BAL);
            r_new   <= {1'b0, ~r_fs} + {1'b0, ~r_fr};
          end
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_full || w_funds || w_ovf) begin
            reject_o <= 1'b1;
            reason_o <= w_full ? 2'd2 : w_funds ? 2'd1 : 2'd3;
            count_o  <= r_n;
            r_state  <= S_IDLE;
          end else begin
            valid_o  <= 1'b1;
            r_state  <= S_WR_S;
          end
        end
        S_WR_S: r_state <= S_WR_R;
        S_WR_R: begin
          count_o <= r_n + CW'(r_new);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trans_ledger_validator.sv
// Directed bench for trans_ledger_validator: vector table of transfers
// with hand-computed outcomes, plus a mid-scan reset sequence.
module tb_trans_ledger_validator;

  localparam int ID_W = 16, BAL_W = 8, AMT_W = 8, DATA_W = 32;
  localparam int DEPTH = 16, LANES = 4, INIT_BAL = 100;
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [ID_W-1:0]   sender_i = '0, receiver_i = '0;
  logic [AMT_W-1:0]  amount_i = '0;
  logic              block_start_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0, data_o;
  logic              valid_o, reject_o;
  logic [1:0]        reason_o;
  logic [CW-1:0]     count_o;

  always #5 clk = ~clk;

  trans_ledger_validator #(
    .ID_W(ID_W), .BAL_W(BAL_W), .AMT_W(AMT_W), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .LANES(LANES), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .sender_i(sender_i), .receiver_i(receiver_i), .amount_i(amount_i),
    .block_start_i(block_start_i), .data_i(data_i), .data_o(data_o),
    .valid_o(valid_o), .reject_o(reject_o), .reason_o(reason_o),
    .count_o(count_o)
  );

  typedef struct {
    int snd; int rcv; int amt; bit bs;
    bit ok; int rsn; int cnt; int lat;
  } vec_t;

  vec_t tbl[$];
  int n_run = 0;
  int n_fail = 0;

  function automatic vec_t mk(int s, int r, int a, bit b,
                              bit ok, int rsn, int cnt, int lat);
    vec_t v;
    v.snd = s; v.rcv = r; v.amt = a; v.bs = b;
    v.ok = ok; v.rsn = rsn; v.cnt = cnt; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input logic [DATA_W-1:0] d);
    int lat;
    int w;
    bit got;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", ready_o, 1);
    sender_i = ID_W'(v.snd);
    receiver_i = ID_W'(v.rcv);
    amount_i = AMT_W'(v.amt);
    block_start_i = v.bs;
    data_i = d;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    block_start_i = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      got = valid_o | reject_o;
    end
    chk("pulse_seen", got, 1);
    chk("latency", lat, v.lat);
    chk("valid_o", valid_o, v.ok);
    chk("reject_o", reject_o, !v.ok);
    if (!v.ok) chk("reason_o", reason_o, v.rsn);
    chk("data_o", data_o, d);
    @(posedge clk);
    #1;
    chk("pulse_width", valid_o | reject_o, 0);
    if (v.ok) begin
      lat = 1;
      while (!ready_o && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("ready_lat", lat, 3);
    end
    chk("count_o", count_o, v.cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k;
    // A=1 B=2 C=3 D=4 E=5 X=50 Y=51
    tbl.push_back(mk(1, 2, 30, 1, 1, 0, 2, 3));
    tbl.push_back(mk(1, 2, 71, 0, 0, 1, 2, 4));
    tbl.push_back(mk(1, 1, 50, 0, 1, 0, 2, 4));
    tbl.push_back(mk(1, 2, 71, 0, 0, 1, 2, 4));
    tbl.push_back(mk(2, 1, 130, 0, 1, 0, 2, 4));
    tbl.push_back(mk(2, 1, 1, 0, 0, 1, 2, 4));
    tbl.push_back(mk(1, 3, 0, 0, 1, 0, 3, 4));
    tbl.push_back(mk(3, 2, 100, 1, 1, 0, 2, 3));
    tbl.push_back(mk(4, 2, 50, 0, 1, 0, 3, 4));
    tbl.push_back(mk(1, 2, 10, 0, 0, 3, 3, 4));
    tbl.push_back(mk(1, 2, 5, 0, 1, 0, 4, 4));
    tbl.push_back(mk(1, 2, 0, 0, 1, 0, 4, 4));
    tbl.push_back(mk(1, 2, 1, 0, 0, 3, 4, 4));
    tbl.push_back(mk(1, 4, 96, 0, 0, 1, 4, 4));
    tbl.push_back(mk(1, 4, 95, 0, 1, 0, 4, 4));
    tbl.push_back(mk(4, 4, 145, 0, 1, 0, 4, 4));
    tbl.push_back(mk(2, 3, 255, 0, 1, 0, 4, 4));
    tbl.push_back(mk(2, 5, 0, 0, 1, 0, 5, 4));
    tbl.push_back(mk(50, 51, 101, 1, 0, 1, 0, 3));
    tbl.push_back(mk(50, 51, 100, 0, 1, 0, 2, 3));
    // Fill to capacity: 7 fresh pairs, then single-entry growth to 16
    for (k = 0; k < 7; k++)
      tbl.push_back(mk(100 + 2*k, 101 + 2*k, 0, k == 0, 1, 0,
                       2*k + 2, 3 + (2*k + 3) / 4));
    tbl.push_back(mk(100, 200, 0, 0, 1, 0, 15, 7));
    tbl.push_back(mk(300, 301, 0, 0, 0, 2, 15, 7));
    tbl.push_back(mk(101, 201, 0, 0, 1, 0, 16, 7));
    tbl.push_back(mk(300, 301, 0, 0, 0, 2, 16, 7));
    tbl.push_back(mk(300, 300, 0, 0, 0, 2, 16, 7));
    tbl.push_back(mk(100, 101, 5, 0, 1, 0, 16, 7));
    tbl.push_back(mk(101, 100, 105, 0, 1, 0, 16, 7));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_reject", reject_o, 0);
    chk("rst_reason", reason_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);

    foreach (tbl[i]) run(tbl[i], 32'hA500_0000 + DATA_W'(i));

    // Nine-entry ledger, then reset in the middle of a 4-cycle scan
    for (k = 0; k < 4; k++)
      run(mk(20 + 2*k, 21 + 2*k, 0, k == 0, 1, 0,
             2*k + 2, 3 + (2*k + 3) / 4), 32'hB000_0000 + DATA_W'(k));
    run(mk(40, 20, 0, 0, 1, 0, 9, 5), 32'hB000_0010);
    @(negedge clk);
    chk("pre_rst_ready", ready_o, 1);
    sender_i = 16'd600;
    receiver_i = 16'd601;
    amount_i = '0;
    data_i = 32'hCAFE_0001;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_count", count_o, 0);
    chk("midrst_data", data_o, 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (valid_o || reject_o) seen = 1'b1;
    end
    chk("midrst_no_pulse", seen, 0);
    chk("midrst_count_hold", count_o, 0);
    run(mk(7, 8, 10, 0, 1, 0, 2, 3), 32'hD00D_0001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
